// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding select encodings and register index width.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        STALL    = 2'b01,
        MEMWAIT  = 2'b10,
        REDIRECT = 2'b11
    } state_t;

    // True when a destination register names the source register.
    // x0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_match(input logic [REG_IDX_W-1:0] rd,
                                       input logic [REG_IDX_W-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// ALU operand forwarding selection. Purely combinational; the younger
// EX/MEM result takes precedence over the older MEM/WB result.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idex_rs1,
    input  logic [REG_IDX_W-1:0] idex_rs2,
    input  logic [REG_IDX_W-1:0] exmem_rd,
    input  logic                 exmem_regwrite,
    input  logic [REG_IDX_W-1:0] memwb_rd,
    input  logic                 memwb_regwrite,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b
);

    function automatic logic [1:0] fwd_sel(input logic [REG_IDX_W-1:0] rs);
        if (exmem_regwrite && reg_match(exmem_rd, rs)) begin
            return FWD_EXMEM;
        end else if (memwb_regwrite && reg_match(memwb_rd, rs)) begin
            return FWD_MEMWB;
        end
        return FWD_NONE;
    endfunction

    // Operand source selects for both ALU inputs
    always_comb begin
        forward_a = fwd_sel(idex_rs1);
        forward_b = fwd_sel(idex_rs2);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait hold, branch redirect,
// data-hazard stall and stall/redirect statistics.
// Optional feature macro: PIPE_FORWARDING_EN (adds operand forwarding and
// narrows stalls to load-use only).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] ifid_rs1,
    input  logic [REG_IDX_W-1:0] ifid_rs2,
    input  logic [REG_IDX_W-1:0] idex_rs1,
    input  logic [REG_IDX_W-1:0] idex_rs2,
    input  logic [REG_IDX_W-1:0] idex_rd,
    input  logic                 idex_regwrite,
    input  logic                 idex_memread,
    input  logic [REG_IDX_W-1:0] exmem_rd,
    input  logic                 exmem_regwrite,
    input  logic [REG_IDX_W-1:0] memwb_rd,
    input  logic                 memwb_regwrite,
    input  logic                 branch_taken,
    input  logic                 dmem_busy,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 pipe_hold,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b,
    output logic [15:0]          stall_cycles,
    output logic [7:0]           flush_count
);

    state_t state, next_state;
    logic   hazard;
    logic   redirect;

`ifdef PIPE_FORWARDING_EN
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       unused_ok;

    pipe_fwd_unit u_fwd (
        .idex_rs1       (idex_rs1),
        .idex_rs2       (idex_rs2),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .forward_a      (fwd_a_raw),
        .forward_b      (fwd_b_raw)
    );

    // With forwarding only a load feeding the very next instruction must stall
    always_comb begin
        hazard = idex_memread &&
                 (reg_match(idex_rd, ifid_rs1) || reg_match(idex_rd, ifid_rs2));
        forward_a = reset ? fwd_a_raw : FWD_NONE;
        forward_b = reset ? fwd_b_raw : FWD_NONE;
    end

    assign unused_ok = &{1'b0, idex_regwrite};
`else
    logic unused_ok;

    // Without forwarding any in-flight producer in EX or MEM blocks the reader;
    // MEM/WB is safe because the register file writes before it reads
    always_comb begin
        hazard = (idex_regwrite &&
                  (reg_match(idex_rd, ifid_rs1) || reg_match(idex_rd, ifid_rs2))) ||
                 (exmem_regwrite &&
                  (reg_match(exmem_rd, ifid_rs1) || reg_match(exmem_rd, ifid_rs2)));
        forward_a = FWD_NONE;
        forward_b = FWD_NONE;
    end

    assign unused_ok = &{1'b0, idex_rs1, idex_rs2, idex_memread, memwb_rd, memwb_regwrite};
`endif

    // FSM state register; reset abandons any hold, stall or pending redirect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state and pipeline controls, priority memory wait > branch > hazard
    always_comb begin
        next_state  = state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_hold   = 1'b0;
        redirect    = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            next_state  = RUN;
        end else if (dmem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            next_state = MEMWAIT;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            redirect    = 1'b1;
            next_state  = REDIRECT;
        end else if (hazard && (state != REDIRECT)) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            next_state = STALL;
        end else begin
            next_state = RUN;
        end
    end

    // Saturating statistics: stalled cycles and branch redirects
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (redirect && (flush_count != 8'hFF)) begin
                flush_count <= flush_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Covers the default build and,
// when PIPE_FORWARDING_EN is defined, the forwarding build.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic        idex_regwrite, idex_memread, exmem_regwrite, memwb_regwrite;
    logic        branch_taken, dmem_busy;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold;
    logic [1:0]  forward_a, forward_b;
    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;

    typedef struct {
        logic        pcw;
        logic        ifw;
        logic [2:0]  fl;
        logic        hold;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] stall;
        logic [7:0]  flush;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_stall = 0;
    int          m_flush = 0;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ifid_rs1       (ifid_rs1),
        .ifid_rs2       (ifid_rs2),
        .idex_rs1       (idex_rs1),
        .idex_rs2       (idex_rs2),
        .idex_rd        (idex_rd),
        .idex_regwrite  (idex_regwrite),
        .idex_memread   (idex_memread),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .branch_taken   (branch_taken),
        .dmem_busy      (dmem_busy),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .pipe_hold      (pipe_hold),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        chk({tag, "_pcw"},   {15'd0, pc_write},   {15'd0, e.pcw});
        chk({tag, "_ifw"},   {15'd0, ifid_write}, {15'd0, e.ifw});
        chk({tag, "_flush"}, {13'd0, ifid_flush, idex_flush, exmem_flush}, {13'd0, e.fl});
        chk({tag, "_hold"},  {15'd0, pipe_hold},  {15'd0, e.hold});
        chk({tag, "_fa"},    {14'd0, forward_a},  {14'd0, e.fa});
        chk({tag, "_fb"},    {14'd0, forward_b},  {14'd0, e.fb});
        chk({tag, "_stallcnt"}, stall_cycles, e.stall);
        chk({tag, "_flushcnt"}, {8'd0, flush_count}, {8'd0, e.flush});
    endtask

    // One clock cycle: expectation queued with the current inputs, compared
    // mid-cycle, model counters advanced, then step past the next rising edge.
    task automatic expect_cycle(input string tag, input logic pcw, input logic ifw,
                                input logic [2:0] fl, input logic hold,
                                input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.hold = hold; e.fa = fa; e.fb = fb;
        e.stall = 16'(m_stall);
        e.flush = 8'(m_flush);
        exp_q.push_back(e);
        @(negedge clk);
        compare_front(tag);
        if (!pcw && m_stall < 65535) m_stall++;
        if (pcw && fl == 3'b111 && m_flush < 255) m_flush++;
        @(posedge clk);
        #1;
    endtask

    // Immediate check of the reset-driven outputs
    task automatic expect_reset(input string tag);
        exp_t e;
        m_stall = 0;
        m_flush = 0;
        e.pcw = 1'b0; e.ifw = 1'b0; e.fl = 3'b111; e.hold = 1'b0;
        e.fa = FWD_NONE; e.fb = FWD_NONE; e.stall = 16'd0; e.flush = 8'd0;
        exp_q.push_back(e);
        #1;
        compare_front(tag);
    endtask

    task automatic clear_inputs();
        ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0;
        exmem_rd = 0; memwb_rd = 0;
        idex_regwrite = 0; idex_memread = 0; exmem_regwrite = 0; memwb_regwrite = 0;
        branch_taken = 0; dmem_busy = 0;
    endtask

    // A load into x3 whose result is read by the instruction in IF/ID;
    // a hazard in both builds
    task automatic set_hazard();
        idex_rd = 5'd3; idex_regwrite = 1'b1; idex_memread = 1'b1; ifid_rs1 = 5'd3;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        exmem_rd = 5'd7; exmem_regwrite = 1'b1; idex_rs2 = 5'd7;
        @(posedge clk);
        expect_reset("reset_hold");
        @(posedge clk);
        #1;
        clear_inputs();
        reset = 1'b1;
        expect_cycle("idle", 1, 1, 3'b000, 0, 2'b00, 2'b00);

`ifdef PIPE_FORWARDING_EN
        idex_rd = 5'd5; idex_memread = 1'b1; idex_regwrite = 1'b1; ifid_rs1 = 5'd5;
        expect_cycle("loaduse", 0, 0, 3'b010, 0, 2'b00, 2'b00);
        clear_inputs();
        expect_cycle("loaduse_after", 1, 1, 3'b000, 0, 2'b00, 2'b00);
        exmem_rd = 5'd7; exmem_regwrite = 1'b1; memwb_rd = 5'd7; memwb_regwrite = 1'b1;
        idex_rs2 = 5'd7;
        expect_cycle("fwd_exmem_b", 1, 1, 3'b000, 0, 2'b00, FWD_EXMEM);
        exmem_regwrite = 1'b0;
        expect_cycle("fwd_memwb_b", 1, 1, 3'b000, 0, 2'b00, FWD_MEMWB);
        idex_rs1 = 5'd7; idex_rs2 = 5'd0; exmem_regwrite = 1'b1;
        expect_cycle("fwd_exmem_a", 1, 1, 3'b000, 0, FWD_EXMEM, 2'b00);
        clear_inputs();
        idex_rd = 5'd3; idex_regwrite = 1'b1; ifid_rs2 = 5'd3;
        expect_cycle("alu_dep_nostall", 1, 1, 3'b000, 0, 2'b00, 2'b00);
`else
        idex_rd = 5'd3; idex_regwrite = 1'b1; ifid_rs2 = 5'd3;
        expect_cycle("nofwd_ex", 0, 0, 3'b010, 0, 2'b00, 2'b00);
        idex_rd = 5'd0; idex_regwrite = 1'b0; exmem_rd = 5'd3; exmem_regwrite = 1'b1;
        expect_cycle("nofwd_mem", 0, 0, 3'b010, 0, 2'b00, 2'b00);
        exmem_rd = 5'd0; exmem_regwrite = 1'b0; memwb_rd = 5'd3; memwb_regwrite = 1'b1;
        expect_cycle("nofwd_wb", 1, 1, 3'b000, 0, 2'b00, 2'b00);
        clear_inputs();
        exmem_rd = 5'd9; exmem_regwrite = 1'b1; idex_rs2 = 5'd9; idex_rs1 = 5'd9;
        expect_cycle("fwd_tied", 1, 1, 3'b000, 0, 2'b00, 2'b00);
`endif
        clear_inputs();
        idex_rd = 5'd0; idex_regwrite = 1'b1; idex_memread = 1'b1; ifid_rs1 = 5'd0;
        exmem_rd = 5'd0; exmem_regwrite = 1'b1; idex_rs1 = 5'd0;
        expect_cycle("x0", 1, 1, 3'b000, 0, 2'b00, 2'b00);

        clear_inputs();
        set_hazard();
        dmem_busy = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) expect_cycle("memwait", 0, 0, 3'b000, 1, 2'b00, 2'b00);
        dmem_busy = 1'b0;
        expect_cycle("redirect", 1, 1, 3'b111, 0, 2'b00, 2'b00);
        branch_taken = 1'b0;
        expect_cycle("redirect_suppress", 1, 1, 3'b000, 0, 2'b00, 2'b00);
        expect_cycle("post_redirect_stall", 0, 0, 3'b010, 0, 2'b00, 2'b00);
        clear_inputs();
        expect_cycle("back_to_run", 1, 1, 3'b000, 0, 2'b00, 2'b00);

        branch_taken = 1'b1;
        for (int i = 0; i < 258; i++) expect_cycle("redir_burst", 1, 1, 3'b111, 0, 2'b00, 2'b00);
        branch_taken = 1'b0;
        expect_cycle("flush_sat", 1, 1, 3'b000, 0, 2'b00, 2'b00);

        dmem_busy = 1'b1; branch_taken = 1'b1;
        expect_cycle("wait_before_rst", 0, 0, 3'b000, 1, 2'b00, 2'b00);
        reset = 1'b0;
        expect_reset("rst_in_memwait");
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_inputs();
        set_hazard();
        expect_cycle("run_after_rst", 0, 0, 3'b010, 0, 2'b00, 2'b00);
        clear_inputs();
        expect_cycle("counts_after_rst", 1, 1, 3'b000, 0, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low
- ifid_rs1, ifid_rs2  in  5  source registers of the instruction in IF/ID
- idex_rs1, idex_rs2  in  5  source registers of the instruction in ID/EX
- idex_rd  in  5  ID/EX destination register
- idex_regwrite, idex_memread  in  1  ID/EX control bits
- exmem_rd  in  5  EX/MEM destination register
- exmem_regwrite  in  1  EX/MEM control bit
- memwb_rd  in  5  MEM/WB destination register
- memwb_regwrite  in  1  MEM/WB control bit
- branch_taken  in  1  branch resolved taken in the MEM stage
- dmem_busy  in  1  data memory has not completed the access in MEM
- pc_write, ifid_write  out  1  load enables for PC and IF/ID
- ifid_flush, idex_flush, exmem_flush  out  1  synchronous clears to bubble
- pipe_hold  out  1  freezes ID/EX, EX/MEM and MEM/WB
- forward_a, forward_b  out  2  ALU operand source selects
- stall_cycles  out  16  saturating count of stalled cycles
- flush_count  out  8  saturating count of branch redirects

Function
REQ-002 SHALL hold a registered FSM with states RUN, STALL, MEMWAIT and REDIRECT; all other outputs decode combinationally from the state and current inputs.
REQ-003 SHALL apply priority dmem_busy > branch_taken > data hazard when several occur in the same cycle.
REQ-004 SHALL, while dmem_busy=1, drive pc_write=0, ifid_write=0, pipe_hold=1 and all flushes 0, and enter or stay in MEMWAIT.
REQ-005 SHALL, on the first cycle with dmem_busy=0 in MEMWAIT, re-evaluate branch and hazard conditions that cycle; a held branch_taken SHALL then redirect.
REQ-006 SHALL, when branch_taken=1 and dmem_busy=0, assert ifid_flush, idex_flush and exmem_flush with pc_write=1 for one cycle, then spend exactly one cycle in REDIRECT.
REQ-007 SHALL, in REDIRECT, suppress data-hazard stalls, then return to RUN.
REQ-008 SHALL never treat register x0 (index 0) as a hazard or forwarding source.
REQ-009 SHALL, on a data hazard, drive pc_write=0, ifid_write=0 and idex_flush=1, and be in STALL on the following cycle.
REQ-010 SHALL leave STALL for RUN on the first cycle with no hazard.
REQ-011 SHALL treat a MEM/WB match as no hazard, because the register file writes before it reads.
REQ-012 SHALL increment stall_cycles on every cycle with pc_write=0 outside reset, saturating at 16'hFFFF.
REQ-013 SHALL increment flush_count once per redirect, saturating at 8'hFF.

Reset
REQ-014 SHALL, while reset=0, drive pc_write=0, ifid_write=0, all flushes=1, pipe_hold=0 and forward_a=forward_b=2'b00.
REQ-015 SHALL, while reset=0, clear both counters and force the state to RUN.
REQ-016 SHALL, on reset assertion mid-stall or mid-MEMWAIT, abandon the operation immediately with no pending redirect retained.

Configuration
REQ-017 SHALL compile forwarding in only when macro PIPE_FORWARDING_EN is defined.
REQ-018 SHALL, with PIPE_FORWARDING_EN defined, select forward_x=2'b10 when exmem_regwrite=1 and exmem_rd equals idex_rsx.
REQ-019 SHALL, with PIPE_FORWARDING_EN defined and no EX/MEM match, select forward_x=2'b01 when memwb_regwrite=1 and memwb_rd equals idex_rsx, else 2'b00.
REQ-020 SHALL, with PIPE_FORWARDING_EN defined, flag a data hazard only for load-use: idex_memread=1 and idex_rd equals ifid_rs1 or ifid_rs2.
REQ-021 SHALL, without PIPE_FORWARDING_EN, tie forward_a and forward_b to 2'b00.
REQ-022 SHALL, without PIPE_FORWARDING_EN, flag a hazard when ifid_rs1 or ifid_rs2 matches idex_rd with idex_regwrite=1, or exmem_rd with exmem_regwrite=1.

Structure
REQ-023 SHALL place in shared package pipe_ctrl_pkg: the FSM state enum, FWD_NONE=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10, and REG_IDX_W=5.
REQ-024 SHALL implement forwarding selection in one combinational sub-module pipe_fwd_unit, instantiated only under PIPE_FORWARDING_EN.

Verification
REQ-025 Load-use (forwarding on): ld x5 in ID/EX, idex_memread=1, ifid_rs1=5 -> one cycle with pc_write=0 and idex_flush=1, then RUN; stall_cycles=1.
REQ-026 Forward priority: exmem_rd=memwb_rd=7, both regwrite=1, idex_rs2=7 -> forward_b=2'b10; exmem_regwrite=0 -> forward_b=2'b01.
REQ-027 No forwarding: idex_rd=3 with idex_regwrite=1 and ifid_rs2=3 -> 2 stall cycles until the producer leaves EX/MEM; memwb match alone -> no stall.
REQ-028 Simultaneous events: dmem_busy=1 for 3 cycles with branch_taken=1 -> 3 hold cycles, then one flush cycle with pc_write=1; flush_count=1, stall_cycles=3.
REQ-029 x0 and reset: idex_rd=0 with ifid_rs1=0 -> no stall; reset=0 asserted during MEMWAIT -> flushes=1 and counters 0 at once, RUN after release.
